// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared types and period elaboration helpers for the voice allocator
package voice_pkg;

  // Allocator FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV    = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_ISSUE  = 2'd3
  } state_t;

  // Octave -1 semitone frequencies in mHz, carried with three extra fractional
  // digits (value / 1000 = mHz) so the rounded half periods land exactly.
  localparam longint unsigned F0_MHZ_X1000_0  = 64'd8175799;
  localparam longint unsigned F0_MHZ_X1000_1  = 64'd8661957;
  localparam longint unsigned F0_MHZ_X1000_2  = 64'd9177024;
  localparam longint unsigned F0_MHZ_X1000_3  = 64'd9722718;
  localparam longint unsigned F0_MHZ_X1000_4  = 64'd10300861;
  localparam longint unsigned F0_MHZ_X1000_5  = 64'd10913382;
  localparam longint unsigned F0_MHZ_X1000_6  = 64'd11562326;
  localparam longint unsigned F0_MHZ_X1000_7  = 64'd12249857;
  localparam longint unsigned F0_MHZ_X1000_8  = 64'd12978272;
  localparam longint unsigned F0_MHZ_X1000_9  = 64'd13750000;
  localparam longint unsigned F0_MHZ_X1000_10 = 64'd14567618;
  localparam longint unsigned F0_MHZ_X1000_11 = 64'd15433853;

  function automatic longint unsigned semitone_f0(input int s);
    case (s)
      0:       return F0_MHZ_X1000_0;
      1:       return F0_MHZ_X1000_1;
      2:       return F0_MHZ_X1000_2;
      3:       return F0_MHZ_X1000_3;
      4:       return F0_MHZ_X1000_4;
      5:       return F0_MHZ_X1000_5;
      6:       return F0_MHZ_X1000_6;
      7:       return F0_MHZ_X1000_7;
      8:       return F0_MHZ_X1000_8;
      9:       return F0_MHZ_X1000_9;
      10:      return F0_MHZ_X1000_10;
      default: return F0_MHZ_X1000_11;
    endcase
  endfunction

  // round(clk_hz / (2 * f0[s])) with f0 held in micro-hertz units
  function automatic longint unsigned half_period(input longint unsigned clk_hz, input int s);
    longint unsigned f;
    f = semitone_f0(s);
    return (clk_hz * 64'd1000000 + f) / (64'd2 * f);
  endfunction

endpackage

// File: rtl/note_period_rom.sv
// rtl/note_period_rom.sv - semitone half-period ROM with truncating octave shift
module note_period_rom
  import voice_pkg::*;
#(
  parameter longint unsigned CLK_HZ = 64'd12_000_000,
  parameter int              CNT_W  = 20
) (
  input  logic [3:0]       rem,
  input  logic [3:0]       oct,
  output logic [CNT_W-1:0] period
);

  localparam longint unsigned BASE [12] = '{
    half_period(CLK_HZ, 0), half_period(CLK_HZ, 1), half_period(CLK_HZ, 2),
    half_period(CLK_HZ, 3), half_period(CLK_HZ, 4), half_period(CLK_HZ, 5),
    half_period(CLK_HZ, 6), half_period(CLK_HZ, 7), half_period(CLK_HZ, 8),
    half_period(CLK_HZ, 9), half_period(CLK_HZ, 10), half_period(CLK_HZ, 11)
  };

  // The lowest semitone has the longest period; if it fits, every entry fits.
  if (BASE[0] >= (64'd1 << CNT_W)) begin : g_base_too_wide
    $error("note_period_rom: BASE[0] does not fit in CNT_W bits");
  end

  logic [63:0] base_sel;

  // Select the semitone base and shift it down by the octave count
  always_comb begin
    base_sel = 64'd0;
    if (rem < 4'd12) begin
      base_sel = BASE[rem];
    end
    period = CNT_W'(base_sel >> oct);
  end

endmodule

// File: rtl/voice_alloc.sv
// rtl/voice_alloc.sv - note event to oscillator channel allocator
module voice_alloc
  import voice_pkg::*;
#(
  parameter int              N_CH   = 4,
  parameter longint unsigned CLK_HZ = 64'd12_000_000,
  parameter int              CNT_W  = 20
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             noteOnStrb_i,
  input  logic             noteOffStrb_i,
  input  logic [7:0]       note_i,
  output logic             ready_o,
  input  logic [N_CH-1:0]  oscActive_i,
  output logic [N_CH-1:0]  oscNoteOnStrb_o,
  output logic [N_CH-1:0]  oscNoteOffStrb_o,
  output logic [7:0]       oscNote_o,
  output logic [CNT_W-1:0] oscHalfCntPeriod_o
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("voice_alloc: N_CH must be within 1..16");
  end

  state_t          state;
  logic [6:0]      rem;
  logic [3:0]      oct;
  logic [6:0]      note_q;
  logic [N_CH-1:0] owner_valid;
  logic [6:0]      owner_note [N_CH];
  logic [CH_W-1:0] steal_ptr;

  logic            off_hit;
  logic [CH_W-1:0] off_ch;
  logic            ret_hit, free_hit, rel_hit;
  logic [CH_W-1:0] ret_ch, free_ch, rel_ch;
  logic [CH_W-1:0] ch_sel;
  logic            steal;
  logic [CH_W-1:0] steal_next;
  logic [CNT_W-1:0] rom_period;

  function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    return N_CH'(1) << ch;
  endfunction

  note_period_rom #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_rom (
    .rem    (rem[3:0]),
    .oct    (oct),
    .period (rom_period)
  );

  // Find the channel that owns the incoming note-off (lowest index wins)
  always_comb begin
    off_hit = 1'b0;
    off_ch  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (owner_valid[i] && owner_note[i] == note_i[6:0]) begin
        off_hit = 1'b1;
        off_ch  = CH_W'(i);
      end
    end
  end

  // Candidate channels for the latched note-on: retrigger, idle, releasing
  always_comb begin
    ret_hit  = 1'b0;
    ret_ch   = '0;
    free_hit = 1'b0;
    free_ch  = '0;
    rel_hit  = 1'b0;
    rel_ch   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (owner_valid[i] && owner_note[i] == note_q) begin
        ret_hit = 1'b1;
        ret_ch  = CH_W'(i);
      end
      if (!owner_valid[i] && !oscActive_i[i]) begin
        free_hit = 1'b1;
        free_ch  = CH_W'(i);
      end
      if (!owner_valid[i]) begin
        rel_hit = 1'b1;
        rel_ch  = CH_W'(i);
      end
    end
  end

  // Priority pick of the channel; stealing only when every channel is owned
  always_comb begin
    steal      = 1'b0;
    ch_sel     = steal_ptr;
    steal_next = (steal_ptr == CH_W'(N_CH - 1)) ? '0 : steal_ptr + CH_W'(1);
    if (ret_hit) begin
      ch_sel = ret_ch;
    end else if (free_hit) begin
      ch_sel = free_ch;
    end else if (rel_hit) begin
      ch_sel = rel_ch;
    end else begin
      steal = 1'b1;
    end
  end

  // Allocator FSM: accept, divide note into octave/semitone, look up, issue
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state              <= ST_IDLE;
      ready_o            <= 1'b1;
      rem                <= '0;
      oct                <= '0;
      note_q             <= '0;
      owner_valid        <= '0;
      steal_ptr          <= '0;
      oscNoteOnStrb_o    <= '0;
      oscNoteOffStrb_o   <= '0;
      oscNote_o          <= '0;
      oscHalfCntPeriod_o <= '0;
      for (int i = 0; i < N_CH; i++) begin
        owner_note[i] <= '0;
      end
    end else begin
      oscNoteOnStrb_o  <= '0;
      oscNoteOffStrb_o <= '0;
      case (state)
        ST_IDLE: begin
          if (!note_i[7]) begin
            if (noteOffStrb_i) begin
              if (off_hit) begin
                oscNoteOffStrb_o    <= ch_onehot(off_ch);
                owner_valid[off_ch] <= 1'b0;
                ready_o             <= 1'b0;
                state               <= ST_ISSUE;
              end
            end else if (noteOnStrb_i) begin
              rem     <= note_i[6:0];
              oct     <= '0;
              note_q  <= note_i[6:0];
              ready_o <= 1'b0;
              state   <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          if (rem >= 7'd12) begin
            rem <= rem - 7'd12;
            oct <= oct + 4'd1;
          end else begin
            state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          oscNote_o           <= {1'b0, note_q};
          oscHalfCntPeriod_o  <= rom_period;
          oscNoteOnStrb_o     <= ch_onehot(ch_sel);
          owner_valid[ch_sel] <= 1'b1;
          owner_note[ch_sel]  <= note_q;
          if (steal) begin
            steal_ptr <= steal_next;
          end
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          ready_o <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          ready_o <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// tb/tb_voice_alloc.sv - self-checking bench for voice_alloc
module tb_voice_alloc;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        on_s = 1'b0;
  logic        off_s = 1'b0;
  logic [7:0]  note = 8'd0;
  logic [3:0]  act = 4'd0;
  logic        ready;
  logic [3:0]  on_strb;
  logic [3:0]  off_strb;
  logic [7:0]  onote;
  logic [19:0] oper;

  int passed = 0;
  int total = 0;

  voice_alloc #(.N_CH(4), .CLK_HZ(64'd12_000_000), .CNT_W(20)) dut (
    .clk_i              (clk),
    .nrst_i             (nrst),
    .noteOnStrb_i       (on_s),
    .noteOffStrb_i      (off_s),
    .note_i             (note),
    .ready_o            (ready),
    .oscActive_i        (act),
    .oscNoteOnStrb_o    (on_strb),
    .oscNoteOffStrb_o   (off_strb),
    .oscNote_o          (onote),
    .oscHalfCntPeriod_o (oper)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Expected half period from the musical definition, computed in real math
  function automatic int ref_period(input int n);
    real f, b;
    int base;
    f = 8.1757989156 * (2.0 ** ((n % 12) / 12.0));
    b = 12000000.0 / (2.0 * f);
    base = $rtoi(b + 0.5);
    return base >> (n / 12);
  endfunction

  // Reference model of the owner table for the random phase
  int own [4];
  int sptr;
  int held_note, held_per;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) own[i] = -1;
    sptr = 0;
    held_note = 0;
    held_per = 0;
  endtask

  task automatic model_predict(input bit on_v, input bit off_v, input int n, input logic [3:0] a,
                               output int kind, output int ch);
    kind = 0;
    ch = 0;
    if (n >= 128) return;
    if (off_v) begin
      for (int i = 0; i < 4; i++) if (own[i] == n && kind == 0) begin kind = 2; ch = i; end
      if (kind == 2) own[ch] = -1;
      return;
    end
    if (!on_v) return;
    kind = 1;
    ch = -1;
    for (int i = 0; i < 4; i++) if (ch < 0 && own[i] == n) ch = i;
    for (int i = 0; i < 4; i++) if (ch < 0 && own[i] < 0 && !a[i]) ch = i;
    for (int i = 0; i < 4; i++) if (ch < 0 && own[i] < 0) ch = i;
    if (ch < 0) begin ch = sptr; sptr = (sptr + 1) % 4; end
    own[ch] = n;
    held_note = n;
    held_per = ref_period(n);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    on_s = 1'b0;
    off_s = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  // Apply one event and observe a 16-cycle window after the accepting edge.
  // inject_c > 0 pulses a both-strobes note-off on 67 during that window.
  task automatic run_event(input int id, input bit on_v, input bit off_v, input logic [7:0] n,
                           input logic [3:0] a, input int kind, input int ch,
                           input int hn, input int hp, input int inject_c);
    int got_c, n_str, rdy_c, got_on, got_off, exp_c, exp_rdy, exp_on, exp_off;
    int w;
    w = 0;
    while (!ready && w < 40) begin @(negedge clk); w++; end
    check($sformatf("ev%0d ready_before", id), ready, 1);
    on_s = on_v;
    off_s = off_v;
    note = n;
    act = a;
    @(posedge clk);
    got_c = 0; n_str = 0; rdy_c = 0; got_on = 0; got_off = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if ((on_strb | off_strb) != 4'd0) begin
        n_str++;
        if (got_c == 0) begin got_c = c; got_on = on_strb; got_off = off_strb; end
      end
      if (ready && rdy_c == 0) rdy_c = c;
      if (c == 1) begin on_s = 1'b0; off_s = 1'b0; end
      if (inject_c > 0 && c == inject_c) begin on_s = 1'b1; off_s = 1'b1; note = 8'd67; end
      if (inject_c > 0 && c == inject_c + 1) begin on_s = 1'b0; off_s = 1'b0; end
    end
    exp_c   = (kind == 1) ? (int'(n) / 12 + 3) : (kind == 2) ? 1 : 0;
    exp_rdy = (kind == 0) ? 1 : exp_c + 1;
    exp_on  = (kind == 1) ? (1 << ch) : 0;
    exp_off = (kind == 2) ? (1 << ch) : 0;
    check($sformatf("ev%0d strobe_cycle", id), got_c, exp_c);
    check($sformatf("ev%0d on_strobe", id), got_on, exp_on);
    check($sformatf("ev%0d off_strobe", id), got_off, exp_off);
    check($sformatf("ev%0d strobe_count", id), n_str, (kind == 0) ? 0 : 1);
    check($sformatf("ev%0d ready_cycle", id), rdy_c, exp_rdy);
    check($sformatf("ev%0d note", id), onote, hn);
    check($sformatf("ev%0d period", id), oper, hp);
  endtask

  typedef struct {
    bit         on;
    bit         off;
    logic [7:0] n;
    logic [3:0] a;
    int         kind;
    int         ch;
    int         hn;
    int         hp;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int kind, ch, n_str, r;
    bit on_v, off_v;
    logic [7:0] n_v;
    logic [3:0] a_v;

    // kind: 0 dropped, 1 note-on, 2 note-off; hn/hp are held bus values afterwards
    vecs[0]  = '{1'b1, 1'b0, 8'd69,  4'b0000, 1, 0, 69,  13636};
    vecs[1]  = '{1'b0, 1'b1, 8'd69,  4'b0001, 2, 0, 69,  13636};
    vecs[2]  = '{1'b1, 1'b0, 8'd60,  4'b0000, 1, 0, 60,  22933};
    vecs[3]  = '{1'b0, 1'b1, 8'd60,  4'b0001, 2, 0, 60,  22933};
    vecs[4]  = '{1'b0, 1'b1, 8'd60,  4'b0001, 0, 0, 60,  22933};
    vecs[5]  = '{1'b1, 1'b0, 8'd60,  4'b0001, 1, 1, 60,  22933};
    vecs[6]  = '{1'b1, 1'b0, 8'd60,  4'b0011, 1, 1, 60,  22933};
    vecs[7]  = '{1'b0, 1'b1, 8'd61,  4'b0011, 0, 0, 60,  22933};
    vecs[8]  = '{1'b1, 1'b0, 8'h80,  4'b0011, 0, 0, 60,  22933};
    vecs[9]  = '{1'b1, 1'b1, 8'd60,  4'b0011, 2, 1, 60,  22933};
    vecs[10] = '{1'b1, 1'b0, 8'd0,   4'b0000, 1, 0, 0,   733873};
    vecs[11] = '{1'b1, 1'b0, 8'd127, 4'b0001, 1, 1, 127, 478};
    vecs[12] = '{1'b1, 1'b0, 8'd64,  4'b1111, 1, 2, 64,  18202};
    vecs[13] = '{1'b1, 1'b0, 8'd65,  4'b1111, 1, 3, 65,  17180};
    vecs[14] = '{1'b1, 1'b0, 8'd67,  4'b1111, 1, 0, 67,  15306};
    vecs[15] = '{1'b1, 1'b0, 8'd69,  4'b1111, 1, 1, 69,  13636};
    vecs[16] = '{1'b1, 1'b0, 8'd67,  4'b1111, 1, 0, 67,  15306};

    do_reset();
    check("reset on_strobe", on_strb, 0);
    check("reset off_strobe", off_strb, 0);
    check("reset note", onote, 0);
    check("reset period", oper, 0);
    check("reset ready", ready, 1);

    for (int i = 0; i < 17; i++) begin
      run_event(i, vecs[i].on, vecs[i].off, vecs[i].n, vecs[i].a,
                vecs[i].kind, vecs[i].ch, vecs[i].hn, vecs[i].hp, 0);
    end

    // Note-on 100 steals ch2; a note-off for 67 arriving during DIV is ignored
    run_event(100, 1'b1, 1'b0, 8'd100, 4'b1111, 1, 2, 100, 2275, 2);
    run_event(101, 1'b0, 1'b1, 8'd67, 4'b1111, 2, 0, 100, 2275, 0);

    // Reset during DIV of note 127 aborts with no strobe and clears everything
    on_s = 1'b1;
    note = 8'd127;
    act = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    on_s = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check("midreset on_strobe", on_strb, 0);
    check("midreset note", onote, 0);
    check("midreset period", oper, 0);
    check("midreset ready", ready, 1);
    nrst = 1'b1;
    n_str = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if ((on_strb | off_strb) != 4'd0) n_str++;
    end
    check("midreset no_strobe", n_str, 0);
    run_event(102, 1'b0, 1'b1, 8'd69, 4'b0000, 0, 0, 0, 0, 0);
    run_event(103, 1'b0, 1'b1, 8'd100, 4'b0000, 0, 0, 0, 0, 0);
    run_event(104, 1'b1, 1'b0, 8'd50, 4'b0000, 1, 0, 50, 40862, 0);

    // Randomized events against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      on_v  = (r < 5) || (r == 8);
      off_v = (r >= 5) && (r <= 8);
      if ($urandom_range(0, 9) == 0) n_v = 8'($urandom_range(128, 255));
      else if ($urandom_range(0, 3) == 0) n_v = 8'($urandom_range(0, 127));
      else n_v = 8'($urandom_range(58, 66));
      a_v = 4'($urandom_range(0, 15));
      model_predict(on_v, off_v, int'(n_v), a_v, kind, ch);
      run_event(200 + i, on_v, off_v, n_v, a_v, kind, ch, held_note, held_per, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/voice_alloc.md
# voice_alloc

Voice allocator between the note-event source (MIDI decoder) and the bank of `N_CH` `osc` channels. It accepts note-on/off events, assigns each note-on to an oscillator channel, and retires note-offs to the owning channel. It computes the half-period count for the chosen note and drives per-channel one-cycle `noteOnStrb`/`noteOffStrb` pulses plus shared `note`/`halfCntPeriod` buses into the oscillators.

## Interface
- `N_CH`, 4 — number of oscillator channels, 1..16
- `CLK_HZ`, 12_000_000 — system clock frequency, used to elaborate the period ROM
- `CNT_W`, 20 — width of the half-period count
- `clk_i` in 1 — system clock
- `nrst_i` in 1 — reset. One clock; reset is synchronous and active-low.
- `noteOnStrb_i` in 1 — one-cycle note-on event
- `noteOffStrb_i` in 1 — one-cycle note-off event
- `note_i` in 8 — MIDI note number qualifying the strobes
- `ready_o` out 1 — high when an event will be accepted this cycle
- `oscActive_i` in `N_CH` — `active_o` of each oscillator
- `oscNoteOnStrb_o` out `N_CH` — one-hot note-on pulse to a channel
- `oscNoteOffStrb_o` out `N_CH` — one-hot note-off pulse to a channel
- `oscNote_o` out 8 — note for the strobed channel; held between issues
- `oscHalfCntPeriod_o` out `CNT_W` — half-period count for the strobed channel; held between issues

## Operation
- **Reset values.** Every output is 0 except `ready_o`, which is 1. The owner table is cleared to all invalid, the steal pointer is 0, and the FSM is in IDLE.
- **FSM states:** IDLE, DIV, LOOKUP, ISSUE. `ready_o` is 1 only in IDLE.
- **Event acceptance.** An event is accepted only in IDLE.
  - `note_i[7]`=1: event dropped, FSM stays in IDLE.
  - Both strobes high in the same cycle: treated as note-off; the note-on is dropped.
  - Strobes arriving while `ready_o`=0 are dropped silently.
- **Note-off path.** IDLE compares `note_i` against the owner table.
  - Match on channel i: go to ISSUE, pulse `oscNoteOffStrb_o[i]`, clear `owner_valid[i]`. `oscNote_o` and `oscHalfCntPeriod_o` are unchanged.
  - No match: dropped.
- **Note-on path, note division.** IDLE latches `rem`=`note_i` and `oct`=0, then moves to DIV.
  - DIV, each cycle: if `rem`≥12, then `rem`-=12 and `oct`+=1; otherwise go to LOOKUP.
- **Note-on path, period.** LOOKUP computes `period` = `BASE[rem] >> oct`, where the shift truncates.
  - `BASE[s]` = round(`CLK_HZ` / (2·f0[s])), with f0[s] the octave −1 frequencies (8.1758 Hz · 2^(s/12)).
- **Channel choice**, evaluated in LOOKUP, first rule that applies:
  1. A channel whose `owner_valid` is set with `owner_note`==note: retrigger that channel.
  2. Lowest i with `!owner_valid[i] && !oscActive_i[i]`.
  3. Lowest i with `!owner_valid[i]`, i.e. a channel in release.
  4. Steal the channel at the steal pointer, then advance the pointer by 1 modulo `N_CH`.
- **ISSUE (note-on).** Drive `oscNote_o` and `oscHalfCntPeriod_o`, pulse `oscNoteOnStrb_o[ch]` for exactly one cycle, and set owner[ch] = {valid, note}. A stolen channel gets no note-off; the oscillator retriggers on the note-on.
- **Reset mid-operation.** Synchronous reset in any state aborts the event with no strobe emitted; all state returns to reset values on the next edge.
- **Width rule.** `BASE[0]` must fit in `CNT_W`; elaboration fails via a static check otherwise.

## Timing
- **Note-on** accepted at cycle 0, with `oct` = note/12:
  - DIV occupies cycles 1..oct+1.
  - LOOKUP is cycle oct+2.
  - The strobe is high in cycle oct+3.
  - `ready_o` returns in cycle oct+4.
- **Note-off** accepted at cycle 0: strobe in cycle 1, `ready_o` in cycle 2.
- `oscNote_o` and `oscHalfCntPeriod_o` are valid in the strobe cycle and stable until the next note-on ISSUE.
- At most one bit of `oscNoteOnStrb_o | oscNoteOffStrb_o` is high in any cycle.

## Structure
- **Package `voice_pkg`** holds:
  - the FSM state enum;
  - the 12 semitone base frequencies as constants in mHz;
  - a function `half_period(CLK_HZ, s)` that elaborates `BASE`.
- **Sub-module `note_period_rom`** holds the 12-entry `BASE` ROM and the truncating shift by `oct`. It is purely combinational, and its output is registered in LOOKUP.
- The top module holds the FSM, the divider, the owner table and the steal pointer.

## Test plan
- Reset, then note-on 69 at cycle 0 with all channels idle → `oscNoteOnStrb_o`=0001 in cycle 8, `oscNote_o`=69, `oscHalfCntPeriod_o`=13636, `ready_o`=1 in cycle 9.
- Note-on 60, then note-off 60 → on-strobe to ch0 with period 22933; off-strobe to ch0 one cycle after acceptance; owner[0] invalid afterwards.
- Note-ons 60, 62, 64, 65, 67 with `oscActive_i` following the strobes → channels 0,1,2,3, then 67 steals ch0; the next steal goes to ch1.
- Note-on 60 twice → both strobes go to ch0 (retrigger); note-off 61 produces no strobe.
- Note-on and note-off both high, note 60 owned by ch2 → only `oscNoteOffStrb_o[2]` pulses. A strobe during DIV is dropped. `note_i`=0x80 is dropped.
- Assert `nrst_i`=0 during DIV of note 127 → no strobe, outputs zero, `ready_o`=1 after release, owner table empty.
